// File: rtl/uart_rx.sv
// uart_rx: bus-attached 8N1 UART receiver with a receive FIFO, sticky
// overflow/framing flags and a level interrupt while data is pending.
// Optional build macro UART_RX_PARITY_EN switches the line format to 8E1
// and adds a parity-error flag in STATUS bit 4.
//
// Bus handshake: every device_req_i is accepted immediately. Exactly one
// cycle later device_rvalid_o pulses high with device_rdata_o, for reads and
// for writes. Writes always return rdata 0 and only act when be[0] is set.
module uart_rx #(
    parameter int ClockFrequency = 50_000_000,
    parameter int BaudRate       = 115_200,
    parameter int RxFifoDepth    = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        device_req_i,
    input  logic [31:0] device_addr_i,
    input  logic        device_we_i,
    input  logic [3:0]  device_be_i,
    input  logic [31:0] device_wdata_i,
    output logic        device_rvalid_o,
    output logic [31:0] device_rdata_o,
    input  logic        uart_rx_i,
    output logic        irq_o
);

    localparam int ClksPerBit = ClockFrequency / BaudRate;
    localparam int CntW       = $clog2(ClksPerBit + 1);
    localparam int AW         = $clog2(RxFifoDepth);
    localparam logic [CntW-1:0] HalfCnt = CntW'(ClksPerBit / 2);
    localparam logic [CntW-1:0] LastCnt = CntW'(ClksPerBit - 1);
    localparam logic [AW:0]     FullCnt = (AW + 1)'(RxFifoDepth);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [1:0]      sync_q;
    logic            rx_s;
    logic            push, frame_set;

    logic [7:0]      mem [RxFifoDepth];
    logic [AW:0]     wr_ptr, rd_ptr, fifo_cnt;
    logic            empty, full, push_ok, pop, ovf_set;

    logic            ovf, frame_err, par_err, irq_en;
    logic [1:0]      addr;
    logic            rd_req, wr_req, wr_status;
    logic [31:0]     rdata_d, status_w;
    logic            irq_d;

    // Two-flop synchroniser for the asynchronous serial line (idles high)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], uart_rx_i};
    end
    assign rx_s = sync_q[1];

`ifdef UART_RX_PARITY_EN
    logic par_set;
`endif

    // Receiver FSM state and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Receiver FSM next-state: mid-bit sampling driven by the clock counter
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_set   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HalfCnt) begin
                    cnt_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    par_set = (rx_s != ^shift_q);
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == LastCnt) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ST_BREAK: begin
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus decode; only be[0] gates writes
    assign addr      = device_addr_i[3:2];
    assign rd_req    = device_req_i & ~device_we_i;
    assign wr_req    = device_req_i & device_we_i & device_be_i[0];
    assign wr_status = wr_req & (addr == 2'd1);

    // FIFO: a pop in the same cycle frees the slot for a push when full
    assign fifo_cnt = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (fifo_cnt == FullCnt);
    assign pop      = rd_req & (addr == 2'd0) & ~empty;
    assign push_ok  = push & (~full | pop);
    assign ovf_set  = push & full & ~pop;

    // FIFO storage (no reset needed, guarded by the pointers)
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= shift_q;
    end

    // FIFO pointers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    // Sticky flags (set wins over a simultaneous clear) and CTRL register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf       <= 1'b0;
            frame_err <= 1'b0;
            irq_en    <= 1'b0;
        end else begin
            ovf       <= ovf_set   | (ovf       & ~(wr_status & device_wdata_i[2]));
            frame_err <= frame_set | (frame_err & ~(wr_status & device_wdata_i[3]));
            if (wr_req && addr == 2'd2) irq_en <= device_wdata_i[0];
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity-error sticky flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) par_err <= 1'b0;
        else         par_err <= par_set | (par_err & ~(wr_status & device_wdata_i[4]));
    end
    assign irq_d = irq_en & (~empty | ovf | frame_err | par_err);
`else
    assign par_err = 1'b0;
    assign irq_d   = irq_en & (~empty | ovf | frame_err);
`endif

    assign status_w = {27'd0, par_err, frame_err, ovf, full, ~empty};

    // Read data mux; writes and the unused offset return 0
    always_comb begin
        rdata_d = '0;
        if (rd_req) begin
            case (addr)
                2'd0:    rdata_d[7:0] = empty ? 8'd0 : mem[rd_ptr[AW-1:0]];
                2'd1:    rdata_d      = status_w;
                2'd2:    rdata_d[0]   = irq_en;
                default: rdata_d      = '0;
            endcase
        end
    end

    // Registered bus response and interrupt
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            device_rvalid_o <= 1'b0;
            device_rdata_o  <= '0;
            irq_o           <= 1'b0;
        end else begin
            device_rvalid_o <= device_req_i;
            device_rdata_o  <= rdata_d;
            irq_o           <= irq_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic unused_bits;
    assign unused_bits = ^{device_addr_i[31:4], device_addr_i[1:0],
                           device_be_i[3:1], device_wdata_i[31:5],
                           device_wdata_i[1]};
`else
    logic unused_bits;
    assign unused_bits = ^{device_addr_i[31:4], device_addr_i[1:0],
                           device_be_i[3:1], device_wdata_i[31:4],
                           device_wdata_i[1]};
`endif

endmodule
